// File: rtl/acumulador_cor_quadrante.sv
// ---------------------------------------------------------------------------
// acumulador_cor_quadrante
// Averages RGB565 camera pixels per quadrant of a 3x3 grid over one frame and
// then streams the 9 averaged colours out with a valid/ready handshake.
//
// Ports
//   clock            system clock, rising edge
//   reset            synchronous active-high reset
//   iniciar          pulse: clear accumulators and arm capture of one frame
//   dado_byte        camera byte, qualified by we_byte
//   we_byte          1-cycle strobe for dado_byte
//   linha_quadrante  quadrant row (0..2), valid with we_byte
//   coluna_quadrante quadrant column (0..2), valid with we_byte
//   fim_frame        pulse: end of captured frame
//   pronto_leitura   consumer ready
//   saida_valida     result word valid
//   saida_quadrante  result quadrant index 0..8
//   saida_r/g/b      averaged colour components
//   saida_completa   quadrant received the full pixel quota
//   pronto           all 9 results accepted
//   erro_quadrante   sticky: a pixel arrived with row or column = 3
//   db_estado        current FSM state code
//
// state   | code | meaning
// OCIOSO  | 0    | idle, waiting for iniciar
// LIMPA   | 1    | one cycle clearing sums, counters, phase, index, error
// ACUMULA | 2    | capturing bytes and accumulating pixels
// ENVIA   | 3    | presenting the 9 results, one per accepted word
// FIM     | 4    | all results delivered, waiting for iniciar
// ---------------------------------------------------------------------------
module acumulador_cor_quadrante #(
   parameter int LOG2_AMOSTRAS = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [7:0] dado_byte,
   input  logic       we_byte,
   input  logic [1:0] linha_quadrante,
   input  logic [1:0] coluna_quadrante,
   input  logic       fim_frame,
   input  logic       pronto_leitura,
   output logic       saida_valida,
   output logic [3:0] saida_quadrante,
   output logic [4:0] saida_r,
   output logic [5:0] saida_g,
   output logic [4:0] saida_b,
   output logic       saida_completa,
   output logic       pronto,
   output logic       erro_quadrante,
   output logic [2:0] db_estado
);

   localparam int L = LOG2_AMOSTRAS;

   localparam logic [2:0] OCIOSO  = 3'd0;
   localparam logic [2:0] LIMPA   = 3'd1;
   localparam logic [2:0] ACUMULA = 3'd2;
   localparam logic [2:0] ENVIA   = 3'd3;
   localparam logic [2:0] FIM     = 3'd4;

   logic [2:0]   r_estado;
   logic [2:0]   w_prox;

   logic [5+L-1:0] r_soma_r [0:8];
   logic [6+L-1:0] r_soma_g [0:8];
   logic [5+L-1:0] r_soma_b [0:8];
   logic [L:0]     r_cont   [0:8];

   logic         r_fase;
   logic [7:0]   r_alto;
   logic         r_pix_valido;
   logic [15:0]  r_pix;
   logic [3:0]   r_pix_q;
   logic [3:0]   r_indice;
   logic         r_erro;

   logic         w_aceite;
   logic [3:0]   w_q;
   logic         w_fora;

   // q = 3*linha + coluna
   assign w_q    = {1'b0, linha_quadrante, 1'b0} + {2'b00, linha_quadrante}
                 + {2'b00, coluna_quadrante};
   assign w_fora = (linha_quadrante == 2'd3) || (coluna_quadrante == 2'd3);

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_estado <= OCIOSO;
      else       r_estado <= w_prox;
   end

   // Next-state logic
   always_comb begin
      w_prox = OCIOSO;
      case (r_estado)
         OCIOSO:  w_prox = iniciar ? LIMPA : OCIOSO;
         LIMPA:   w_prox = ACUMULA;
         ACUMULA: begin
            if (iniciar)        w_prox = LIMPA;
            else if (fim_frame) w_prox = ENVIA;
            else                w_prox = ACUMULA;
         end
         ENVIA:   w_prox = (w_aceite && (r_indice == 4'd8)) ? FIM : ENVIA;
         FIM:     w_prox = iniciar ? LIMPA : FIM;
         default: w_prox = OCIOSO;
      endcase
   end

   // Output logic. A pixel whose last byte coincided with fim_frame is still
   // in flight during the first ENVIA cycle; valid is held off until it has
   // landed in the sums so the first word is never stale.
   always_comb begin
      saida_valida    = 1'b0;
      saida_quadrante = 4'd0;
      saida_r         = 5'd0;
      saida_g         = 6'd0;
      saida_b         = 5'd0;
      saida_completa  = 1'b0;
      pronto          = (r_estado == FIM);
      erro_quadrante  = r_erro;
      db_estado       = r_estado;
      if (r_estado == ENVIA) begin
         saida_valida    = ~r_pix_valido;
         saida_quadrante = r_indice;
         saida_r         = r_soma_r[r_indice][L +: 5];
         saida_g         = r_soma_g[r_indice][L +: 6];
         saida_b         = r_soma_b[r_indice][L +: 5];
         // counter saturates at exactly 2^L, so its MSB marks a full quota
         saida_completa  = r_cont[r_indice][L];
      end
      w_aceite = saida_valida & pronto_leitura;
   end

   // Datapath
   always_ff @(posedge clock) begin
      if (reset || (r_estado == LIMPA)) begin
         for (int i = 0; i < 9; i++) begin
            r_soma_r[i] <= '0;
            r_soma_g[i] <= '0;
            r_soma_b[i] <= '0;
            r_cont[i]   <= '0;
         end
         r_fase       <= 1'b0;
         r_alto       <= 8'd0;
         r_pix_valido <= 1'b0;
         r_pix        <= 16'd0;
         r_pix_q      <= 4'd0;
         r_indice     <= 4'd0;
         r_erro       <= 1'b0;
      end else begin
         r_pix_valido <= 1'b0;

         if (r_pix_valido && !r_cont[r_pix_q][L]) begin
            r_soma_r[r_pix_q] <= r_soma_r[r_pix_q] + {{L{1'b0}}, r_pix[15:11]};
            r_soma_g[r_pix_q] <= r_soma_g[r_pix_q] + {{L{1'b0}}, r_pix[10:5]};
            r_soma_b[r_pix_q] <= r_soma_b[r_pix_q] + {{L{1'b0}}, r_pix[4:0]};
            r_cont[r_pix_q]   <= r_cont[r_pix_q] + (L+1)'(1);
         end

         if ((r_estado == ACUMULA) && we_byte) begin
            r_fase <= ~r_fase;
            if (!r_fase) begin
               r_alto <= dado_byte;
            end else if (w_fora) begin
               r_erro <= 1'b1;
            end else begin
               r_pix_valido <= 1'b1;
               r_pix        <= {r_alto, dado_byte};
               r_pix_q      <= w_q;
            end
         end

         if (w_aceite && (r_indice != 4'd8))
            r_indice <= r_indice + 4'd1;
      end
   end

endmodule

// File: doc/acumulador_cor_quadrante.md
ACUMULADOR_COR_QUADRANTE -- requirements
Module: acumulador_cor_quadrante

Interface
REQ-001 The block SHALL have parameter LOG2_AMOSTRAS, default 6: log2 of the pixels averaged per quadrant (64).
REQ-002 The block SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port iniciar, input, 1, a pulse that clears the accumulators and arms capture of one frame.
REQ-005 The block SHALL have port dado_byte, input, 8, the camera byte presented with we_byte.
REQ-006 The block SHALL have port we_byte, input, 1, a 1-cycle strobe meaning dado_byte belongs to the current quadrant.
REQ-007 The block SHALL have ports linha_quadrante and coluna_quadrante, input, 2 each, the quadrant row/column (0..2) valid with we_byte.
REQ-008 The block SHALL have port fim_frame, input, 1, a pulse marking the end of the captured frame.
REQ-009 The block SHALL have port pronto_leitura, input, 1, consumer ready.
REQ-010 The block SHALL have ports saida_valida (1), saida_quadrante (4), saida_r (5), saida_g (6), saida_b (5) and saida_completa (1), all outputs, forming the result word and its valid flag.
REQ-011 The block SHALL have port pronto, output, 1, high once all 9 results have been accepted.
REQ-012 The block SHALL have port erro_quadrante, output, 1, a sticky flag for an out-of-range quadrant index.
REQ-013 The block SHALL have port db_estado, output, 3, the current FSM state code.

Function
REQ-014 FSM states/codes SHALL be: OCIOSO=0, LIMPA=1, ACUMULA=2, ENVIA=3, FIM=4. Unused codes go to OCIOSO.
REQ-015 Transitions SHALL be:
- OCIOSO -> LIMPA on iniciar.
- LIMPA -> ACUMULA unconditionally.
- ACUMULA -> LIMPA on iniciar, which has priority; else ACUMULA -> ENVIA on fim_frame.
- ENVIA -> FIM when index 8 is accepted.
- FIM -> LIMPA on iniciar.
REQ-016 LIMPA SHALL, in one cycle, zero all 9 R/G/B sums, the 9 pixel counters, the byte-phase flag, the output index and erro_quadrante.
REQ-017 In ACUMULA, each we_byte SHALL toggle the byte-phase flag.
- Phase 0: register dado_byte as the high byte.
- Phase 1: form RGB565 {alto,dado_byte}: R=[15:11], G=[10:5], B=[4:0].
REQ-018 The quadrant index q SHALL equal 3*linha_quadrante+coluna_quadrante, sampled with the phase-1 byte.
REQ-019 A completed pixel SHALL be added to the sums of q in the cycle after the phase-1 byte, only while count[q] < 2^LOG2_AMOSTRAS. Count[q] then increments; further pixels for q are discarded.
REQ-020 Sum widths SHALL be 5+L, 6+L and 5+L bits (L=LOG2_AMOSTRAS), with counters L+1 bits, so overflow is impossible.
REQ-021 A phase-1 byte with linha_quadrante=3 or coluna_quadrante=3 SHALL discard the pixel and set erro_quadrante until the next LIMPA.
REQ-022 we_byte outside ACUMULA SHALL be ignored and SHALL NOT toggle the phase flag.
REQ-023 If we_byte and fim_frame coincide in ACUMULA, that byte SHALL be processed and accumulated before the results are presented.
REQ-024 In ENVIA, the outputs for the current index SHALL be:
- saida_valida=1 and saida_quadrante=index.
- saida_r/g/b = sum >> L.
- saida_completa = 1 when count[index] = 2^L.
REQ-025 The handshake SHALL work as follows:
- A word is accepted in a cycle where saida_valida and pronto_leitura are both 1.
- On acceptance the index increments the next cycle.
- The outputs SHALL hold stable while not accepted.
REQ-026 Back-to-back acceptance SHALL sustain 1 word/cycle; 9 words minimum 9 cycles.
REQ-027 pronto SHALL be 1 only in FIM; saida_valida SHALL be 1 only in ENVIA.
REQ-028 iniciar SHALL be ignored in LIMPA and ENVIA; fim_frame SHALL be ignored outside ACUMULA.

Reset
REQ-029 On reset, the state SHALL become OCIOSO and all sums, counters, the phase flag and the index SHALL clear.
REQ-030 Reset values of all outputs SHALL be 0, including saida_* and db_estado.
REQ-031 Reset SHALL take priority over every other input in any state, including mid-ENVIA.

Verification
REQ-032 Reset, then iniciar, then 64 pixels 0xF800 to quadrant (0,0), then fim_frame, with pronto_leitura=1 -> word 0: r=31 g=0 b=0 completa=1; words 1..8 all zero with completa=0; pronto=1 after 9 words.
REQ-033 Send 100 pixels 0x07E0 to (2,2), L=6 -> word 8 has g=63 and completa=1; the extra 36 pixels are ignored.
REQ-034 Send 32 pixels 0x001F to (1,1) -> word 4 has b=15 and completa=0.
REQ-035 Hold pronto_leitura=0 for 5 cycles in ENVIA -> saida_valida=1 and the word held constant at index 0; index advances only after release.
REQ-036 Send a phase-1 byte with coluna_quadrante=3 -> erro_quadrante=1 and no sum changes; the next iniciar clears it.
REQ-037 Assert reset mid-ACUMULA and mid-ENVIA -> all outputs are 0 and db_estado=0 the next cycle; a following frame's results are unaffected by the earlier data.
